// File: rtl/sequence_generator.sv
// Serial pattern transmitter: shifts a WIDTH-bit pattern out MSB-first for (repeat_cnt+1) repetitions.
// Optional feature macro: SEQGEN_GAP_EN inserts one idle GAP cycle between consecutive repetitions.
module sequence_generator #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic             abort,
  output logic             ready,
  output logic             data,
  output logic             valid,
  output logic             frame,
  output logic             done
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

`ifdef SEQGEN_GAP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] copy;
  logic [BW-1:0]    bitcnt;
  logic [CNT_W-1:0] rep;

  // Outputs are registered one step ahead: sh[WIDTH-1] is the bit currently on data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      bitcnt <= '0;
      rep    <= '0;
      ready  <= 1'b1;
      data   <= 1'b0;
      valid  <= 1'b0;
      frame  <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          // abort in DONE beats a simultaneous load; abort in IDLE is ignored
          if (load && !(abort && state == DONE)) begin
            sh     <= pattern;
            copy   <= pattern;
            rep    <= repeat_cnt;
            bitcnt <= '0;
            state  <= SEND;
            ready  <= 1'b0;
            valid  <= 1'b1;
            data   <= pattern[WIDTH-1];
            frame  <= 1'b1;
          end else begin
            state  <= IDLE;
            bitcnt <= '0;
            rep    <= '0;
            ready  <= 1'b1;
            valid  <= 1'b0;
            data   <= 1'b0;
            frame  <= 1'b0;
          end
        end
        SEND: begin
          if (abort) begin
            state  <= IDLE;
            bitcnt <= '0;
            rep    <= '0;
            ready  <= 1'b1;
            valid  <= 1'b0;
            data   <= 1'b0;
            frame  <= 1'b0;
          end else if (bitcnt == LAST_BIT) begin
            if (rep != '0) begin
              rep    <= rep - CNT_W'(1);
              sh     <= copy;
              bitcnt <= '0;
`ifdef SEQGEN_GAP_EN
              state  <= GAP;
              valid  <= 1'b0;
              data   <= 1'b0;
              frame  <= 1'b0;
`else
              valid  <= 1'b1;
              data   <= copy[WIDTH-1];
              frame  <= 1'b1;
`endif
            end else begin
              state  <= DONE;
              done   <= 1'b1;
              ready  <= 1'b1;
              valid  <= 1'b0;
              data   <= 1'b0;
              frame  <= 1'b0;
            end
          end else begin
            sh     <= sh << 1;
            bitcnt <= bitcnt + BW'(1);
            data   <= sh[WIDTH-2];
            frame  <= 1'b0;
          end
        end
`ifdef SEQGEN_GAP_EN
        GAP: begin
          if (abort) begin
            state  <= IDLE;
            bitcnt <= '0;
            rep    <= '0;
            ready  <= 1'b1;
            valid  <= 1'b0;
            data   <= 1'b0;
            frame  <= 1'b0;
          end else begin
            state  <= SEND;
            valid  <= 1'b1;
            data   <= sh[WIDTH-1];
            frame  <= 1'b1;
          end
        end
`endif
        default: begin
          state  <= IDLE;
          bitcnt <= '0;
          rep    <= '0;
          ready  <= 1'b1;
          valid  <= 1'b0;
          data   <= 1'b0;
          frame  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sequence_generator.sv
// Scoreboard bench for sequence_generator: stimulus queues per-cycle expected outputs, a monitor pops and compares.
module tb_sequence_generator;

  localparam int WIDTH = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             load;
  logic             abort;
  logic [WIDTH-1:0] pattern;
  logic [CNT_W-1:0] repeat_cnt;
  logic             ready, data, valid, frame, done;

  sequence_generator #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .pattern    (pattern),
    .repeat_cnt (repeat_cnt),
    .abort      (abort),
    .ready      (ready),
    .data       (data),
    .valid      (valid),
    .frame      (frame),
    .done       (done)
  );

  always #5 clk = ~clk;

  // expected outputs packed as {ready, valid, data, frame, done}
  typedef struct {
    int         cyc;
    logic [4:0] v;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   mon_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [4:0] act;
    exp_t       e;
    if (mon_on) begin
      act = {ready, valid, data, frame, done};
      while (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        checks++;
        failures++;
        $display("FAIL stale_expect cyc=%0d expected entry for cyc %0d never compared", cyc, e.cyc);
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        checks++;
        if (act !== e.v) begin
          failures++;
          $display("FAIL outputs cyc=%0d {ready,valid,data,frame,done} actual=%b required=%b", cyc, act, e.v);
        end
      end else if (valid !== 1'b0 || done !== 1'b0 || data !== 1'b0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output cyc=%0d valid=%b data=%b done=%b required 0 0 0", cyc, valid, data, done);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step();
  endtask

  task automatic push_one(input int c, input logic rd, vl, dt, fr, dn);
    exp_t e;
    e.cyc = c;
    e.v   = {rd, vl, dt, fr, dn};
    q.push_back(e);
  endtask

  task automatic push_tab(input int base, input int n, input logic [31:0] rd, vl, dt, fr, dn);
    for (int i = 0; i < n; i++)
      push_one(base + i, rd[n-1-i], vl[n-1-i], dt[n-1-i], fr[n-1-i], dn[n-1-i]);
  endtask

  task automatic scen_basic();
    int b;
    b = cyc;
    pattern = 4'b1011; repeat_cnt = 4'd0; load = 1'b1;
    push_tab(b, 7, 7'b1000011, 7'b0111100, 7'b0101100, 7'b0100000, 7'b0000010);
    step(); load = 1'b0;
    wait_until(b + 7);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached, queue size %0d required 0", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int t;
    rst_n = 1'b0; load = 1'b0; abort = 1'b0; pattern = '0; repeat_cnt = '0;
    step(); step();

    // reset values, and abort in IDLE has no effect
    b = cyc;
    mon_on = 1'b1;
    rst_n = 1'b1; abort = 1'b1;
    push_tab(b, 2, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
    step(); abort = 1'b0;
    wait_until(b + 2);

    scen_basic();

    // three repetitions of 1101
    b = cyc;
    pattern = 4'b1101; repeat_cnt = 4'd2; load = 1'b1;
`ifdef SEQGEN_GAP_EN
    push_tab(b, 17, 17'b1_0000_0_0000_0_0000_1_1, 17'b0_1111_0_1111_0_1111_0_0,
             17'b0_1101_0_1101_0_1101_0_0, 17'b0_1000_0_1000_0_1000_0_0,
             17'b0_0000_0_0000_0_0000_1_0);
    step(); load = 1'b0;
    wait_until(b + 17);
`else
    push_tab(b, 15, 15'b1_0000_0000_0000_1_1, 15'b0_1111_1111_1111_0_0,
             15'b0_1101_1101_1101_0_0, 15'b0_1000_1000_1000_0_0,
             15'b0_0000_0000_0000_1_0);
    step(); load = 1'b0;
    wait_until(b + 15);
`endif

    // load while busy ignored; load in DONE accepted back-to-back
    b = cyc;
    pattern = 4'b1011; repeat_cnt = 4'd0; load = 1'b1;
    push_tab(b, 12, 12'b1_0000_1_0000_1_1, 12'b0_1111_0_1111_0_0, 12'b0_1011_0_0110_0_0,
             12'b0_1000_0_1000_0_0, 12'b0_0000_1_0000_1_0);
    step(); load = 1'b0;
    step(); load = 1'b1; pattern = 4'b0000; repeat_cnt = 4'd3;
    step(); load = 1'b0;
    step();
    step(); load = 1'b1; pattern = 4'b0110; repeat_cnt = 4'd0;
    step(); load = 1'b0;
    wait_until(b + 12);

    // abort mid-transfer
    b = cyc;
    pattern = 4'b1111; repeat_cnt = 4'd0; load = 1'b1;
    push_tab(b, 7, 7'b1001111, 7'b0110000, 7'b0110000, 7'b0100000, 7'b0000000);
    step(); load = 1'b0;
    step(); abort = 1'b1;
    step(); abort = 1'b0;
    wait_until(b + 7);

    // abort and load together in DONE: load dropped
    b = cyc;
    pattern = 4'b1001; repeat_cnt = 4'd0; load = 1'b1;
    push_tab(b, 8, 8'b1_0000_111, 8'b0_1111_000, 8'b0_1001_000, 8'b0_1000_000, 8'b0_0000_100);
    step(); load = 1'b0;
    wait_until(b + 5);
    abort = 1'b1; load = 1'b1; pattern = 4'b1111;
    step(); abort = 1'b0; load = 1'b0;
    wait_until(b + 8);

    // reset mid-transfer, then a normal transfer
    b = cyc;
    pattern = 4'b1011; repeat_cnt = 4'd0; load = 1'b1;
    push_tab(b, 7, 7'b1000111, 7'b0111000, 7'b0101000, 7'b0100000, 7'b0000000);
    step(); load = 1'b0;
    wait_until(b + 3);
    rst_n = 1'b0; load = 1'b1; abort = 1'b1;
    step(); rst_n = 1'b1; load = 1'b0; abort = 1'b0;
    wait_until(b + 7);
    scen_basic();

    // maximum repeat count: 16 repetitions of 1001, no wrap
    b = cyc;
    pattern = 4'b1001; repeat_cnt = 4'd15; load = 1'b1;
    t = b;
    push_one(t++, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i < 4; i++)
        push_one(t++, 1'b0, 1'b1, (i == 0 || i == 3), (i == 0), 1'b0);
`ifdef SEQGEN_GAP_EN
      if (r != 15) push_one(t++, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif
    end
    push_one(t++, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    push_one(t++, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); load = 1'b0;
    wait_until(t);

    step();
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL queue_drain leftover=%0d required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
